// File: rtl/parallel_axis_frame_capture_if.sv
// AXI-Stream beat bundle for the parallel frame capture: sample data, sideband
// and frame marker with the usual valid/ready pair.
interface parallel_axis_frame_capture_if #(
  parameter int TDATA_W = 64,
  parameter int TUSER_W = 16
);
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/parallel_axis_frame_capture.sv
// Frame-aligned capture buffer for a SAMP_PER_CLK-parallel AXI-Stream of FFT frames:
// stores FRAMES whole frames (optionally decimated) and exposes a registered read port.
module parallel_axis_frame_capture #(
  parameter int SAMP_PER_CLK = 2,
  parameter int DATA_W       = 16,
  parameter int TUSER_W      = 16,
  parameter int FFT_LEN      = 64,
  parameter int FRAMES       = 4,
  localparam int TDATA_W     = SAMP_PER_CLK * 2 * DATA_W,
  localparam int BEATS       = FFT_LEN / SAMP_PER_CLK,
  localparam int DEPTH       = FRAMES * BEATS,
  localparam int AW          = $clog2(DEPTH),
  localparam int FSW         = $clog2(FRAMES + 1),
  localparam int RW          = TDATA_W + TUSER_W
) (
  input  logic                         clk,
  input  logic                         rst,
  parallel_axis_frame_capture_if.slave s_axis,
  input  logic                         arm,
  input  logic [7:0]                   skip,
  input  logic [AW-1:0]                rd_addr,
  output logic [RW-1:0]                rd_data,
  output logic                         busy,
  output logic                         full,
  output logic [FSW-1:0]               frames_stored,
  output logic [15:0]                  err_tlast_early,
  output logic [15:0]                  err_tlast_missing,
  output logic [1:0]                   dbg_state
);

  localparam int BCW = $clog2(BEATS);
  localparam logic [BCW-1:0] LAST_BC    = BCW'(BEATS - 1);
  localparam logic [BCW-1:0] BC_ONE     = BCW'(1);
  localparam logic [AW-1:0]  AW_ONE     = AW'(1);
  localparam logic [FSW-1:0] FS_ONE     = FSW'(1);
  localparam logic [FSW-1:0] FRAMES_M1  = FSW'(FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Valid/ready: a beat transfers on any rising clk edge where tvalid and tready
  // are both high; tready is low during reset and high otherwise.
  state_t         state, state_nx;
  logic           ready_r;
  logic [BCW-1:0] bc;
  logic [7:0]     sc;
  logic [7:0]     skip_r;
  logic [AW-1:0]  wp;
  logic [AW-1:0]  base;
  logic           accept, store, last_beat;
  logic           start, wr_en, end_good, end_early, end_missing;

  logic [RW-1:0]  mem [DEPTH];

  assign s_axis.tready = ready_r & ~rst;
  assign accept        = s_axis.tvalid & s_axis.tready;
  // sc tracks frame count modulo (skip_r+1); zero marks a frame to keep.
  assign store         = (sc == 8'd0);
  assign last_beat     = (bc == LAST_BC);

  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    wr_en       = 1'b0;
    end_good    = 1'b0;
    end_early   = 1'b0;
    end_missing = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          start    = 1'b1;
          state_nx = SYNC;
        end
      end
      SYNC: begin
        if (accept && s_axis.tlast) state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (accept) begin
          wr_en = store;
          if (s_axis.tlast && last_beat) begin
            end_good = 1'b1;
            if (store && frames_stored == FRAMES_M1) state_nx = DONE;
          end else if (s_axis.tlast) begin
            end_early = 1'b1;
          end else if (last_beat) begin
            end_missing = 1'b1;
            state_nx    = SYNC;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ready_r           <= 1'b0;
      bc                <= '0;
      sc                <= '0;
      skip_r            <= '0;
      wp                <= '0;
      base              <= '0;
      frames_stored     <= '0;
      err_tlast_early   <= '0;
      err_tlast_missing <= '0;
    end else begin
      state   <= state_nx;
      ready_r <= 1'b1;
      if (start) begin
        bc            <= '0;
        sc            <= '0;
        wp            <= '0;
        base          <= '0;
        frames_stored <= '0;
        skip_r        <= skip;
      end
      if (wr_en) wp <= wp + AW_ONE;
      if (end_good) begin
        bc <= '0;
        sc <= (sc == skip_r) ? 8'd0 : sc + 8'd1;
        if (store) begin
          frames_stored <= frames_stored + FS_ONE;
          base          <= wp + AW_ONE;
        end
      end else if (end_early || end_missing) begin
        // A broken frame is discarded by rewinding to where it began.
        bc <= '0;
        wp <= base;
      end else if (state == CAPTURE && accept) begin
        bc <= bc + BC_ONE;
      end
      if (end_early && err_tlast_early != 16'hFFFF)
        err_tlast_early <= err_tlast_early + 16'd1;
      if (end_missing && err_tlast_missing != 16'hFFFF)
        err_tlast_missing <= err_tlast_missing + 16'd1;
    end
  end

  // RAM contents survive reset on purpose so a capture can be read after an abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= {s_axis.tuser, s_axis.tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

  assign busy      = (state == SYNC) || (state == CAPTURE);
  assign full      = (state == DONE);
  assign dbg_state = state;

endmodule
